flex_counter_sched: RTL

- Round-robin scheduler that shares one flex_counter among NUM_REQ requesters.
- Each requester asks for a delay of D cycles. The scheduler grants one requester at a time, loads the counter's rollover value, runs the counter until it rolls over, then pulses that requester's done bit.
- Sits between the requesting engines and a flex_counter instance. It drives the counter's clear, count_enable and rollover_val, and observes rollover_flag.

---
 rtl/flex_counter_sched_pkg.sv | 14 +
 rtl/flex_counter_if.sv | 8 +
 rtl/flex_counter.sv | 41 ++++
 rtl/rr_arbiter.sv | 26 ++
 rtl/flex_counter_sched.sv | 105 ++++++++++
 5 files changed

// File: rtl/flex_counter_sched_pkg.sv
// Shared types and defaults for the flex_counter round-robin scheduler.
package flex_counter_sched_pkg;
  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_NUM_CNT_BITS = 4;
  localparam int GRANT_W          = $clog2(DEF_NUM_REQ);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } sched_state_t;
endpackage

// File: rtl/flex_counter_if.sv
// Bundle of the control/status wires between the scheduler and one flex_counter.
interface flex_counter_if #(parameter int W = 4);
  logic         clear;
  logic         count_enable;
  logic [W-1:0] rollover_val;
  logic [W-1:0] count_out;
  logic         rollover_flag;
endinterface

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear and programmable rollover; flag is registered
// and high while count_out equals rollover_val.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);
  logic [NUM_CNT_BITS-1:0] cnt_q, cnt_d;
  logic                    flag_q, flag_d;

  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (clear) begin
      cnt_d  = '0;
      flag_d = 1'b0;
    end else if (count_enable) begin
      cnt_d  = (cnt_q == rollover_val) ? NUM_CNT_BITS'(1) : cnt_q + 1'b1;
      flag_d = (cnt_d == rollover_val);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign count_out     = cnt_q;
  assign rollover_flag = flag_q;
endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int GW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic [GW-1:0] grant,
  output logic          any_req
);
  logic [GW-1:0] idx;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = GW'((int'(ptr) + i) % N);
      if (req[idx]) begin
        grant   = idx;
        any_req = 1'b1;
      end
    end
  end
endmodule

// File: rtl/flex_counter_sched.sv
// Shares one flex_counter among NUM_REQ requesters; one timed delay per grant.
module flex_counter_sched
  import flex_counter_sched_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int NUM_CNT_BITS = DEF_NUM_CNT_BITS,
  localparam int GW          = $clog2(NUM_REQ)
) (
  input  logic                            CLK,
  input  logic                            nRST,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*NUM_CNT_BITS-1:0] dur,
  output logic [NUM_REQ-1:0]              done,
  output logic                            busy,
  output logic [GW-1:0]                   grant_id,
  output logic                            cnt_clear,
  output logic                            cnt_enable,
  output logic [NUM_CNT_BITS-1:0]         cnt_rollover_val,
  input  logic                            cnt_rollover_flag
);
  sched_state_t            state_q, state_d;
  logic [GW-1:0]           ptr_q, ptr_d;
  logic [GW-1:0]           gid_q, gid_d;
  logic [NUM_CNT_BITS-1:0] rv_q, rv_d;

  logic [GW-1:0]           arb_gnt;
  logic                    arb_any;
  logic [NUM_CNT_BITS-1:0] dur_arr [NUM_REQ];
  logic [NUM_CNT_BITS-1:0] sel_dur;
  logic [GW-1:0]           next_ptr;

  rr_arbiter #(.N(NUM_REQ), .GW(GW)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .grant   (arb_gnt),
    .any_req (arb_any)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) dur_arr[i] = dur[i*NUM_CNT_BITS +: NUM_CNT_BITS];
  end

  assign sel_dur  = dur_arr[arb_gnt];
  assign next_ptr = (gid_q == GW'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gid_d      = gid_q;
    rv_d       = rv_q;
    done       = '0;
    busy       = (state_q != IDLE);
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          gid_d   = arb_gnt;
          rv_d    = sel_dur;
          // A zero delay never touches the counter.
          state_d = (sel_dur == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        cnt_clear = 1'b1;
        state_d   = RUN;
      end
      RUN: begin
        // Hold the counter at D once it gets there so it can never wrap.
        cnt_enable = ~cnt_rollover_flag;
        if (!req[gid_q])            state_d = ABORT;
        else if (cnt_rollover_flag) state_d = DONE;
      end
      DONE: begin
        done[gid_q] = 1'b1;
        cnt_clear   = 1'b1;
        ptr_d       = next_ptr;
        state_d     = IDLE;
      end
      ABORT: begin
        cnt_clear = 1'b1;
        ptr_d     = next_ptr;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      rv_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      rv_q    <= rv_d;
    end
  end

  assign grant_id         = gid_q;
  assign cnt_rollover_val = rv_q;
endmodule
